gmii_tx_framer: RTL and testbench



---
 rtl/gmii_pkg.sv | 13 +
 rtl/gmii_tx_framer_if.sv | 10 +
 rtl/crc32_d8.sv | 18 +
 rtl/gmii_tx_framer.sv | 169 ++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gmii_pkg.sv
// Shared types and constants for the GMII transmit framer.
package gmii_pkg;

  typedef enum logic [3:0] {
    IDLE, PRE, SFD, DATA, PAD, FCS, ABORT, DROP, IFG
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

endpackage

// File: rtl/gmii_tx_framer_if.sv
// Byte-stream handshake (valid/ready/last) feeding the GMII transmit framer.
interface gmii_tx_framer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, s_valid, s_last, input s_ready);
  modport slave  (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/crc32_d8.sv
// One-byte step of the reflected Ethernet CRC-32 (bit 0 of data first).
module crc32_d8
  import gmii_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] next_crc
);

  always_comb begin
    next_crc = crc;
    for (int i = 0; i < 8; i++) begin
      if (next_crc[0] ^ data[i]) next_crc = (next_crc >> 1) ^ CRC_POLY;
      else                       next_crc = next_crc >> 1;
    end
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// Stream-to-GMII transmit framer: preamble, SFD, optional padding (GMII_TX_PAD_EN), FCS, IFG.
//
// state | meaning
// IDLE  | waiting for s_valid; loads first preamble byte on exit
// PRE   | loading remaining preamble bytes
// SFD   | loading start-of-frame delimiter
// DATA  | s_ready=1, accepted bytes go to txd and CRC
// PAD   | loading zero pad bytes up to minimum frame length
// FCS   | loading ~CRC, LSB byte first
// ABORT | underflow marker cycle on the wire (tx_er)
// DROP  | discarding bytes until s_last
// IFG   | inter-frame gap, tx_en low
module gmii_tx_framer
  import gmii_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned MIN_FRAME    = 60,
  parameter int unsigned IFG_BYTES    = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  gmii_tx_framer_if.slave   s,
  output logic [7:0]        gmii_txd,
  output logic              gmii_tx_en,
  output logic              gmii_tx_er
);

  // The IDLE exit already loads one preamble byte, so PRE covers the rest.
  localparam logic [7:0] PRE_LOAD = 8'(PREAMBLE_LEN - 2);
  localparam logic [7:0] IFG_LOAD = 8'(IFG_BYTES - 1);

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [31:0] crc, crc_nx, crc_upd, fcs_word;
  logic [7:0]  crc_data, txd_nx;
  logic        en_nx, er_nx;
  logic [4:0]  fcs_sh;

`ifdef GMII_TX_PAD_EN
  localparam logic [10:0] MIN_CNT = 11'(MIN_FRAME);
  logic [10:0] bcnt, bcnt_nx, bcnt_inc;
  assign bcnt_inc = (bcnt == 11'h7FF) ? bcnt : bcnt + 11'd1;
`endif

  assign s.s_ready = (state == DATA) || (state == ABORT) || (state == DROP);
  assign crc_data  = (state == PAD) ? 8'h00 : s.s_data;
  assign fcs_word  = ~crc;
  assign fcs_sh    = {cnt[1:0], 3'b000};

  crc32_d8 u_crc (.crc(crc), .data(crc_data), .next_crc(crc_upd));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    crc_nx   = crc;
    txd_nx   = 8'h00;
    en_nx    = 1'b0;
    er_nx    = 1'b0;
`ifdef GMII_TX_PAD_EN
    bcnt_nx  = bcnt;
`endif
    case (state)
      IDLE: if (s.s_valid) begin
        state_nx = PRE;
        cnt_nx   = PRE_LOAD;
        txd_nx   = PREAMBLE_BYTE;
        en_nx    = 1'b1;
      end
      PRE: begin
        txd_nx = PREAMBLE_BYTE;
        en_nx  = 1'b1;
        if (cnt == 8'd0) state_nx = SFD;
        else             cnt_nx   = cnt - 8'd1;
      end
      SFD: begin
        txd_nx   = SFD_BYTE;
        en_nx    = 1'b1;
        crc_nx   = CRC_INIT;
        state_nx = DATA;
`ifdef GMII_TX_PAD_EN
        bcnt_nx  = 11'd0;
`endif
      end
      DATA: if (s.s_valid) begin
        txd_nx = s.s_data;
        en_nx  = 1'b1;
        crc_nx = crc_upd;
`ifdef GMII_TX_PAD_EN
        bcnt_nx = bcnt_inc;
        if (s.s_last) begin
          if (bcnt_inc < MIN_CNT) state_nx = PAD;
          else begin
            state_nx = FCS;
            cnt_nx   = 8'd0;
          end
        end
`else
        if (s.s_last) begin
          state_nx = FCS;
          cnt_nx   = 8'd0;
        end
`endif
      end else begin
        en_nx    = 1'b1;
        er_nx    = 1'b1;
        state_nx = ABORT;
      end
`ifdef GMII_TX_PAD_EN
      PAD: begin
        en_nx   = 1'b1;
        crc_nx  = crc_upd;
        bcnt_nx = bcnt_inc;
        if (bcnt_inc >= MIN_CNT) begin
          state_nx = FCS;
          cnt_nx   = 8'd0;
        end
      end
`endif
      FCS: begin
        txd_nx = fcs_word[fcs_sh +: 8];
        en_nx  = 1'b1;
        if (cnt[1:0] == 2'd3) begin
          state_nx = IFG;
          cnt_nx   = IFG_LOAD;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      ABORT, DROP: begin
        if (s.s_valid && s.s_last) begin
          state_nx = IFG;
          cnt_nx   = IFG_LOAD;
        end else begin
          state_nx = DROP;
        end
      end
      IFG: begin
        if (cnt == 8'd0) state_nx = IDLE;
        else             cnt_nx   = cnt - 8'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      crc        <= CRC_INIT;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
`ifdef GMII_TX_PAD_EN
      bcnt       <= 11'd0;
`endif
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      crc        <= crc_nx;
      gmii_txd   <= txd_nx;
      gmii_tx_en <= en_nx;
      gmii_tx_er <= er_nx;
`ifdef GMII_TX_PAD_EN
      bcnt       <= bcnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer; expectations follow GMII_TX_PAD_EN when defined.
module tb_gmii_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] txd;
  logic       en, er;

  int n_tests = 0;
  int n_fail  = 0;

  gmii_tx_framer_if sif ();

  gmii_tx_framer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (sif),
    .gmii_txd   (txd),
    .gmii_tx_en (en),
    .gmii_tx_er (er)
  );

  always #4 clk = ~clk;

  logic [7:0] cap[$];
  logic [7:0] exp_q[$];
  int  er_cnt = 0, er_bad = 0, idle_run = 0, last_gap = 0, ready_gaps = 0;
  bit  prev_en = 1'b0;
  bit  abort_drv = 1'b0;

  initial forever begin
    @(negedge clk);
    if (en) begin
      cap.push_back(txd);
      if (!prev_en) last_gap = idle_run;
      idle_run = 0;
    end else begin
      idle_run++;
    end
    if (er) begin
      er_cnt++;
      if (!en || txd != 8'h00) er_bad++;
    end
    prev_en = en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic add_frame(input logic [7:0] p[$]);
    logic [7:0]  body[$];
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    body = p;
`ifdef GMII_TX_PAD_EN
    while (body.size() < 60) body.push_back(8'h00);
`endif
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (body[i]) begin
      exp_q.push_back(body[i]);
      c = c ^ {24'h0, body[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
  endtask

  task automatic compare_cap(input string tag);
    check({tag, " len"}, cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      check($sformatf("%s byte%0d", tag, i), {24'h0, cap[i]}, {24'h0, exp_q[i]});
  endtask

  task automatic clear_obs();
    cap.delete();
    exp_q.delete();
    er_cnt = 0;
    er_bad = 0;
  endtask

  task automatic send(input logic [7:0] p[$], input int stall_at, input bit hold);
    int idx = 0;
    int guard = 0;
    bit stalled = 1'b0;
    ready_gaps = 0;
    while (idx < p.size()) begin
      @(negedge clk);
      if (abort_drv) break;
      guard++;
      if (guard > 3000) begin
        check("send timeout", idx, p.size());
        break;
      end
      if (!stalled && idx == stall_at) begin
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        stalled     = 1'b1;
      end else begin
        sif.s_data  = p[idx];
        sif.s_valid = 1'b1;
        sif.s_last  = (idx == p.size() - 1);
        if (stalled && !sif.s_ready) ready_gaps++;
        if (sif.s_ready) idx++;
      end
    end
    if (abort_drv) begin
      sif.s_valid = 1'b0;
      sif.s_last  = 1'b0;
    end else if (!hold) begin
      @(negedge clk);
      sif.s_valid = 1'b0;
      sif.s_last  = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int run = 0;
    int guard = 0;
    while (run < 16 && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (en) run = 0;
      else    run++;
    end
    if (run < 16) check("idle timeout", run, 16);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p9[$], p60[$], p1[$], pu[$], pb[$], p20[$];
    p9  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    p60 = '{8'h51, 8'h55, 8'h42, 8'h49, 8'h43, 8'h01, 8'hC4, 8'h6E,
            8'h1F, 8'h01, 8'hD9, 8'h0D, 8'h08, 8'h00, 8'h45, 8'h00};
    while (p60.size() < 60) p60.push_back(8'h00);
    p1  = '{8'hAB};
    pu  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    pb  = '{8'hAA, 8'hBB, 8'hCC};
    for (int i = 0; i < 20; i++) p20.push_back(8'(8'h40 + i));

    sif.s_data  = 8'h00;
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;

    repeat (3) @(negedge clk);
    check("reset txd", {24'h0, txd}, 32'h0);
    check("reset tx_en", {31'h0, en}, 32'h0);
    check("reset tx_er", {31'h0, er}, 32'h0);
    check("reset s_ready", {31'h0, sif.s_ready}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 9-byte check string
    clear_obs();
    add_frame(p9);
    send(p9, -1, 1'b0);
    wait_idle();
    compare_cap("crc9");
`ifndef GMII_TX_PAD_EN
    if (cap.size() >= 21) begin
      check("crc9 fcs0", {24'h0, cap[17]}, 32'h26);
      check("crc9 fcs1", {24'h0, cap[18]}, 32'h39);
      check("crc9 fcs2", {24'h0, cap[19]}, 32'hF4);
      check("crc9 fcs3", {24'h0, cap[20]}, 32'hCB);
    end else begin
      check("crc9 short", cap.size(), 21);
    end
`endif

    // 60-byte frame, no padding needed
    clear_obs();
    add_frame(p60);
    send(p60, -1, 1'b0);
    wait_idle();
    compare_cap("udp60");
    check("udp60 tx_en cycles", cap.size(), 72);

    // 1-byte payload
    clear_obs();
    add_frame(p1);
    send(p1, -1, 1'b0);
    wait_idle();
    compare_cap("one");
`ifdef GMII_TX_PAD_EN
    check("one tx_en cycles", cap.size(), 72);
`else
    check("one tx_en cycles", cap.size(), 13);
`endif

    // underflow after 5 data bytes
    clear_obs();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 5; i++) exp_q.push_back(pu[i]);
    exp_q.push_back(8'h00);
    send(pu, 5, 1'b0);
    wait_idle();
    compare_cap("abort");
    check("abort er cycles", er_cnt, 1);
    check("abort er shape", er_bad, 0);
    check("abort ready gaps", ready_gaps, 0);

    // back-to-back with s_valid held
    clear_obs();
    add_frame(p9);
    add_frame(pb);
    send(p9, -1, 1'b1);
    send(pb, -1, 1'b0);
    wait_idle();
    compare_cap("b2b");
    check("b2b gap", last_gap, 12);
    check("b2b er", er_cnt, 0);

    // reset mid-DATA
    clear_obs();
    fork
      send(p20, -1, 1'b0);
      begin
        repeat (20) @(negedge clk);
        check("mid frame tx_en", {31'h0, en}, 32'h1);
        abort_drv = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async rst tx_en", {31'h0, en}, 32'h0);
        check("async rst txd", {24'h0, txd}, 32'h0);
        check("async rst s_ready", {31'h0, sif.s_ready}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    abort_drv = 1'b0;
    repeat (2) @(negedge clk);
    clear_obs();
    add_frame(p9);
    send(p9, -1, 1'b0);
    wait_idle();
    compare_cap("post rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
